// File: rtl/credit_pkg.sv
// Shared types and constants for the receiver-side credit issuer.
// Holds the issuer state enum, counter widths and default sizing.
package credit_pkg;

    typedef enum logic {
        ADV,
        RUN
    } state_t;

    localparam int CNT_W       = 4;
    localparam int BEAT_W      = 2;

    localparam int DEF_DEPTH   = 15;
    localparam int DEF_THRESH  = 3;
    localparam int DEF_TIMEOUT = 4;

endpackage

// File: rtl/credit_coalesce_timer.sv
// Saturating idle timer used to force a partial credit return.
// Ports: clk, rst (sync, active-low), clear, pending_nz -> expired.
module credit_coalesce_timer
    import credit_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pending_nz,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Counts only while credits are waiting; held at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || !pending_nz) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/credit_return.sv
// Receiver credit issuer: tracks buffer occupancy, advertises credits
// after reset / init_req and returns freed slots in beats of 1..3.
// Ports: clk, rst (sync, active-low), init_req, slot_take,
//   slot_free_valid, slot_free_cnt -> reinit, initial_value,
//   incr_valid, incr, occupancy, err.
module credit_return
    import credit_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int THRESH  = DEF_THRESH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    input  logic             slot_take,
    input  logic             slot_free_valid,
    input  logic [1:0]       slot_free_cnt,
    output logic             reinit,
    output logic [3:0]       initial_value,
    output logic             incr_valid,
    output logic [1:0]       incr,
    output logic [3:0]       occupancy,
    output logic             err
);

    localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(3);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  occ, occ_nx;
    logic [CNT_W-1:0]  pend, pend_nx;
    logic [CNT_W-1:0]  freed;
    logic [CNT_W:0]    occ_sum, occ_diff, pend_sum;
    logic [BEAT_W-1:0] ret;
    logic              err_nx;
    logic              tmr_clear;
    logic              expired;

    credit_coalesce_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmr_clear),
        .pending_nz(pend != '0),
        .expired   (expired)
    );

    always_comb begin
        state_nx = state;
        err_nx   = err;
        ret      = '0;
        freed    = slot_free_valid ?
                   {{(CNT_W-BEAT_W){1'b0}}, slot_free_cnt} : '0;
        occ_sum  = {1'b0, occ} + {{CNT_W{1'b0}}, slot_take};
        occ_diff = occ_sum - {1'b0, freed};
        occ_nx   = occ_diff[CNT_W-1:0];
        pend_sum = {1'b0, freed};

        // Occupancy clamps to 0..DEPTH; any overrun is a protocol error.
        if (slot_take && (occ == DEPTH_C || state == ADV)) begin
            err_nx = 1'b1;
        end
        if ({1'b0, freed} > occ_sum) begin
            err_nx = 1'b1;
            occ_nx = '0;
        end else if (occ_diff > DEPTH_X) begin
            err_nx = 1'b1;
            occ_nx = DEPTH_C;
        end

        case (state)
            ADV: begin
                // Advertise drops whatever was pending; only this
                // cycle's frees remain owed to the sender.
                state_nx = RUN;
            end
            RUN: begin
                if (init_req) begin
                    state_nx = ADV;
                end
                if (pend >= THRESH_C || expired) begin
                    ret = (pend > BEAT_MAX) ? BEAT_W'(3)
                                            : pend[BEAT_W-1:0];
                end
                pend_sum = {1'b0, pend}
                         - {{(CNT_W+1-BEAT_W){1'b0}}, ret}
                         + {1'b0, freed};
            end
            default: state_nx = ADV;
        endcase

        pend_nx = pend_sum[CNT_W-1:0];
        if (pend_sum > DEPTH_X) begin
            err_nx  = 1'b1;
            pend_nx = DEPTH_C;
        end

        tmr_clear = (state == ADV) || (ret != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ADV;
            occ           <= '0;
            pend          <= '0;
            err           <= 1'b0;
            reinit        <= 1'b0;
            initial_value <= '0;
            incr_valid    <= 1'b0;
            incr          <= '0;
        end else begin
            state      <= state_nx;
            occ        <= occ_nx;
            pend       <= pend_nx;
            err        <= err_nx;
            reinit     <= (state == ADV);
            incr_valid <= (ret != '0);
            incr       <= ret;
            if (state == ADV) begin
                initial_value <= DEPTH_C - occ;
            end
        end
    end

    assign occupancy = occ;

endmodule

// File: tb/tb_credit_return.sv
// Self-checking bench for credit_return: directed vector table,
// hand-written corner sequences and randomized model comparison.
module tb_credit_return;

    localparam int DEPTH   = 15;
    localparam int THRESH  = 3;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_req;
    logic       slot_take;
    logic       slot_free_valid;
    logic [1:0] slot_free_cnt;
    logic       reinit;
    logic [3:0] initial_value;
    logic       incr_valid;
    logic [1:0] incr;
    logic [3:0] occupancy;
    logic       err;

    always #5 clk = ~clk;

    credit_return #(
        .DEPTH  (DEPTH),
        .THRESH (THRESH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .init_req       (init_req),
        .slot_take      (slot_take),
        .slot_free_valid(slot_free_valid),
        .slot_free_cnt  (slot_free_cnt),
        .reinit         (reinit),
        .initial_value  (initial_value),
        .incr_valid     (incr_valid),
        .incr           (incr),
        .occupancy      (occupancy),
        .err            (err)
    );

    typedef struct {
        bit ir;
        bit tk;
        bit fv;
        int fc;
        bit re;
        int ival;
        bit iv;
        int inc;
        int occ;
    } vec_t;

    vec_t vq[$];

    int errors = 0;
    int checks = 0;

    // Reference model state (plain integers, spec rules).
    bit m_adv, m_reinit, m_iv, m_err;
    int m_occ, m_pend, m_tmr, m_ival, m_incr;
    int sender;

    function automatic vec_t V(bit ir, bit tk, bit fv, int fc,
                               bit re, int ival, bit iv, int inc,
                               int occ);
        vec_t v;
        v.ir = ir; v.tk = tk; v.fv = fv; v.fc = fc;
        v.re = re; v.ival = ival; v.iv = iv; v.inc = inc;
        v.occ = occ;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ir, input bit tk,
                              input bit fv, input int fc);
        int fr, o, ret, np;
        if (!r) begin
            m_adv = 1; m_reinit = 0; m_iv = 0; m_err = 0;
            m_occ = 0; m_pend = 0; m_tmr = 0; m_ival = 0; m_incr = 0;
            return;
        end
        fr = fv ? fc : 0;
        if (tk && (m_adv || m_occ == DEPTH)) m_err = 1;
        o = m_occ + int'(tk) - fr;
        if (o < 0) begin m_err = 1; o = 0; end
        if (o > DEPTH) begin m_err = 1; o = DEPTH; end
        if (m_adv) begin
            m_reinit = 1;
            m_ival = DEPTH - m_occ;
            m_iv = 0;
            m_incr = 0;
            np = fr;
            m_tmr = 0;
            m_adv = 0;
        end else begin
            m_reinit = 0;
            ret = 0;
            if (m_pend >= THRESH || m_tmr == TIMEOUT)
                ret = (m_pend < 3) ? m_pend : 3;
            m_iv = (ret > 0);
            m_incr = ret;
            np = m_pend - ret + fr;
            if (ret > 0 || m_pend == 0) m_tmr = 0;
            else if (m_tmr < TIMEOUT) m_tmr++;
            if (ir) m_adv = 1;
        end
        if (np > DEPTH) begin m_err = 1; np = DEPTH; end
        m_occ = o;
        m_pend = np;
    endtask

    task automatic tick(input bit r, input bit ir, input bit tk,
                        input bit fv, input int fc);
        bit v_re, v_iv;
        int v_ival, v_inc;
        v_re = reinit;
        v_iv = incr_valid;
        v_ival = int'(initial_value);
        v_inc = int'(incr);
        rst = r;
        init_req = ir;
        slot_take = tk;
        slot_free_valid = fv;
        slot_free_cnt = 2'(fc);
        @(posedge clk);
        #1;
        if (!r) sender = 0;
        else if (v_re) sender = v_ival;
        else sender = sender + (v_iv ? v_inc : 0) - int'(tk);
        model_step(r, ir, tk, fv, fc);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".reinit"}, int'(reinit), int'(m_reinit));
        chk({tag, ".incr_valid"}, int'(incr_valid), int'(m_iv));
        chk({tag, ".occupancy"}, int'(occupancy), m_occ);
        chk({tag, ".err"}, int'(err), int'(m_err));
        if (m_reinit)
            chk({tag, ".initial_value"}, int'(initial_value), m_ival);
        if (m_iv)
            chk({tag, ".incr"}, int'(incr), m_incr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".reinit"}, int'(reinit), 0);
        chk({tag, ".initial_value"}, int'(initial_value), 0);
        chk({tag, ".incr_valid"}, int'(incr_valid), 0);
        chk({tag, ".incr"}, int'(incr), 0);
        chk({tag, ".occupancy"}, int'(occupancy), 0);
        chk({tag, ".err"}, int'(err), 0);
    endtask

    task automatic chk_inv();
        int act;
        if (reinit)
            act = int'(initial_value) + int'(occupancy) + m_pend;
        else
            act = sender + int'(occupancy) + m_pend
                + (incr_valid ? int'(incr) : 0);
        chk("credit_conservation", act, DEPTH);
    endtask

    initial begin
        bit inv_on;
        bit tk, fv, ir;
        int cap, fc;

        // Advertise, idle, fill 5, free 3 -> threshold return.
        vq.push_back(V(0,0,0,0, 1,15,0,0,0));
        vq.push_back(V(0,0,0,0, 0,0,0,0,0));
        vq.push_back(V(0,0,0,0, 0,0,0,0,0));
        for (int i = 1; i <= 5; i++) vq.push_back(V(0,1,0,0, 0,0,0,0,i));
        vq.push_back(V(0,0,1,3, 0,0,0,0,2));
        vq.push_back(V(0,0,0,0, 0,0,1,3,2));
        vq.push_back(V(0,0,0,0, 0,0,0,0,2));
        // Single free -> timeout return five cycles later.
        vq.push_back(V(0,0,1,1, 0,0,0,0,1));
        for (int i = 0; i < 4; i++) vq.push_back(V(0,0,0,0, 0,0,0,0,1));
        vq.push_back(V(0,0,0,0, 0,0,1,1,1));
        vq.push_back(V(0,0,0,0, 0,0,0,0,1));
        // Pending 2 returned on timeout alongside a free of 3.
        for (int i = 2; i <= 5; i++) vq.push_back(V(0,1,0,0, 0,0,0,0,i));
        vq.push_back(V(0,0,1,2, 0,0,0,0,3));
        for (int i = 0; i < 4; i++) vq.push_back(V(0,0,0,0, 0,0,0,0,3));
        vq.push_back(V(0,0,1,3, 0,0,1,2,0));
        vq.push_back(V(0,0,0,0, 0,0,1,3,0));
        vq.push_back(V(0,0,0,0, 0,0,0,0,0));
        // occ=4 with pending 1, init_req drops pending.
        for (int i = 1; i <= 5; i++) vq.push_back(V(0,1,0,0, 0,0,0,0,i));
        vq.push_back(V(0,0,1,1, 0,0,0,0,4));
        vq.push_back(V(1,0,0,0, 0,0,0,0,4));
        vq.push_back(V(1,0,0,0, 1,11,0,0,4));
        for (int i = 0; i < 6; i++) vq.push_back(V(0,0,0,0, 0,0,0,0,4));

        sender = 0;
        model_step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        chk_zero("reset");

        foreach (vq[i]) begin
            tick(1, vq[i].ir, vq[i].tk, vq[i].fv, vq[i].fc);
            chk($sformatf("row%0d.reinit", i), int'(reinit), int'(vq[i].re));
            if (vq[i].re)
                chk($sformatf("row%0d.initial_value", i),
                    int'(initial_value), vq[i].ival);
            chk($sformatf("row%0d.incr_valid", i),
                int'(incr_valid), int'(vq[i].iv));
            if (vq[i].iv)
                chk($sformatf("row%0d.incr", i), int'(incr), vq[i].inc);
            chk($sformatf("row%0d.occupancy", i), int'(occupancy), vq[i].occ);
            chk($sformatf("row%0d.err", i), int'(err), 0);
        end

        // Overfill: take at occ=15 sets sticky err, occ saturates.
        for (int i = 0; i < 11; i++) begin
            tick(1, 0, 1, 0, 0);
            chk_model("fill");
        end
        chk("fill.occ15", int'(occupancy), 15);
        tick(1, 0, 1, 0, 0);
        chk("over.err", int'(err), 1);
        chk("over.occ", int'(occupancy), 15);
        chk_model("over");
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("over.sticky", int'(err), 1);
        tick(0, 0, 0, 0, 0);
        chk_zero("rst_mid");

        // Reset in the cycle a threshold return would be decided.
        tick(1, 0, 0, 0, 0);
        chk("rel.reinit", int'(reinit), 1);
        chk("rel.ival", int'(initial_value), 15);
        for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 0);
        tick(1, 0, 0, 1, 3);
        chk_model("pre_drop");
        tick(0, 0, 0, 0, 0);
        chk_zero("drop");
        tick(1, 0, 0, 0, 0);
        chk("drop.reinit", int'(reinit), 1);
        chk("drop.ival", int'(initial_value), 15);
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0, 0, 0);
            chk("drop.no_incr", int'(incr_valid), 0);
        end

        // Free 2 at occ=1: underflow error, occ clamps at 0.
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 0, 1, 2);
        chk("under.err", int'(err), 1);
        chk("under.occ", int'(occupancy), 0);
        chk_model("under");

        // Take during the advertise cycle.
        tick(0, 0, 0, 0, 0);
        chk("clr.err", int'(err), 0);
        tick(1, 0, 1, 0, 0);
        chk("adv_take.err", int'(err), 1);
        chk_model("adv_take");

        // Randomized legal traffic against the model.
        tick(0, 0, 0, 0, 0);
        inv_on = 0;
        for (int n = 0; n < 3000; n++) begin
            tk = 0;
            if (!m_adv && !m_reinit && m_occ < DEPTH && sender > 0)
                tk = 1'($urandom_range(1));
            cap = m_occ + int'(tk);
            if (cap > 3) cap = 3;
            fv = ($urandom_range(3) != 0);
            fc = fv ? int'($urandom_range(cap)) : int'($urandom_range(3));
            ir = ($urandom_range(39) == 0);
            tick(1, ir, tk, fv, fc);
            chk_model("rand");
            if (m_reinit) inv_on = 1;
            if (inv_on) chk_inv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
